// File: rtl/seg7_mux_display_pkg.sv
// Shared seven-segment types and the hex-to-cathode decode table.
// Cathode patterns are gfedcba, active low.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
    seg7_t s;
    unique case (nibble)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_mux_display_if.sv
// Load bus carrying the digit word and per-digit masks into the display driver.
interface seg7_mux_display_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;

  modport master (output value_in, output dp_in, output blank_in, output load);
  modport slave  (input  value_in, input  dp_in, input  blank_in, input  load);

endinterface

// File: rtl/seg7_mux_display_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb seg = hex_to_seg7(nibble);

endmodule

// File: rtl/seg7_mux_display.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered digit data,
// leading-zero suppression and per-slot PWM brightness.
module seg7_mux_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIM_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_mux_display_if.slave     bus,
  input  logic                  lz_blank,
  input  logic [DIM_BITS-1:0]   brightness,
  output seg7_t                 seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int unsigned PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SLICE = REFRESH_DIV >> DIM_BITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_val, act_val;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp, sh_blank, act_blank;

  logic                  presc_wrap, frame_wrap;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  seg7_t                 dec_seg;
  logic                  cur_dark;
  logic [31:0]           on_limit;
  logic                  pwm_on;

  always_comb begin
    presc_wrap = (presc == PRESC_LAST);
    frame_wrap = presc_wrap && (idx == IDX_LAST);
  end

  // Walk from the most significant digit down; a digit is a leading zero
  // while every nibble at or above it is zero. Digit 0 is always shown.
  always_comb begin
    zero_run = 1'b1;
    lz_dark  = '0;
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      zero_run     = zero_run & (act_val[4*(i-1) +: 4] == 4'h0);
      lz_dark[i-1] = lz_blank & zero_run & (i != 1);
    end
  end

  always_comb begin
    cur_nib  = act_val[{idx, 2'b00} +: 4];
    cur_dark = act_blank[idx] | lz_dark[idx];
    on_limit = (32'(brightness) + 32'd1) * SLICE;
    // Last prescaler count is forced dark so the registered anode is high on
    // the first cycle of the next slot while seg switches to the new digit.
    pwm_on   = ((&brightness) || (32'(presc) < on_limit)) && !presc_wrap;
  end

  seg7_hex_decoder u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      idx       <= '0;
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      act_val   <= '0;
      act_dp    <= '0;
      act_blank <= '0;
    end else begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (bus.load) begin
        sh_val   <= bus.value_in;
        sh_dp    <= bus.dp_in;
        sh_blank <= bus.blank_in;
      end
      if (frame_wrap) begin
        act_val   <= bus.load ? bus.value_in : sh_val;
        act_dp    <= bus.load ? bus.dp_in    : sh_dp;
        act_blank <= bus.load ? bus.blank_in : sh_blank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (cur_dark) begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
        an  <= '1;
      end else begin
        seg <= dec_seg;
        dp  <= ~act_dp[idx];
        an  <= pwm_on ? ~(NUM_DIGITS'(1) << idx) : '1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_mux_display.sv
// Randomised bench for seg7_mux_display against a time-indexed reference model.
module tb_seg7_mux_display;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 16;
  localparam int unsigned DB = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          lz_blank = 1'b0;
  logic [DB-1:0] brightness = '1;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;
  logic          frame_done;

  seg7_mux_display_if #(.NUM_DIGITS(ND)) bus_if ();

  seg7_mux_display #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DIM_BITS    (DB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference: slot position and digit follow directly from cycles since reset.
  int         t;
  logic [15:0] sh_v, ac_v;
  logic [3:0]  sh_d, ac_d, sh_b, ac_b;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fd;

  always @(posedge clk) begin
    if (reset) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
      t = 0;
      sh_v = '0; ac_v = '0; sh_d = '0; ac_d = '0; sh_b = '0; ac_b = '0;
    end else begin
      int pos, dg, on_cyc;
      logic dark;
      logic [15:0] upper;
      logic [3:0] nib;
      pos    = t % RD;
      dg     = (t / RD) % ND;
      upper  = ac_v >> (4 * dg);
      nib    = upper[3:0];
      dark   = ac_b[dg] || (lz_blank && dg != 0 && upper == 16'h0);
      on_cyc = (int'(brightness) + 1) * (RD >> DB);
      e_fd   = (t % (RD * ND)) == (RD * ND - 1);
      if (dark) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end else begin
        e_seg = seg_tab[nib];
        e_dp  = ~ac_d[dg];
        e_an  = (pos < on_cyc && pos != RD - 1) ? ~(4'b0001 << dg) : 4'hF;
      end
      if (bus_if.load) begin
        sh_v = bus_if.value_in; sh_d = bus_if.dp_in; sh_b = bus_if.blank_in;
      end
      if (e_fd) begin
        ac_v = sh_v; ac_d = sh_d; ac_b = sh_b;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("an", 32'(an), 32'(e_an));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop on the negedge just before the edge that processes (pos, dig).
  task automatic wait_phase(input int pos, input int dig);
    int budget;
    budget = 200;
    while (!((t % RD) == pos && ((t / RD) % ND) == dig) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("wait_phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    bus_if.value_in = v; bus_if.dp_in = d; bus_if.blank_in = b; bus_if.load = 1'b1;
    tick(1);
    bus_if.load = 1'b0;
  endtask

  task automatic count_on(input string tag, input int exp);
    int cnt [4];
    for (int d = 0; d < 4; d++) cnt[d] = 0;
    for (int c = 0; c < 64; c++) begin
      tick(1);
      for (int d = 0; d < 4; d++) if (an == ~(4'b0001 << d)) cnt[d]++;
    end
    for (int d = 0; d < 4; d++) chk($sformatf("%s_d%0d", tag, d), 32'(cnt[d]), 32'(exp));
  endtask

  initial begin
    int fd_cnt;
    bus_if.value_in = '0; bus_if.dp_in = '0; bus_if.blank_in = '0; bus_if.load = 1'b0;
    reset = 1'b1;
    tick(3);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_fd", 32'(frame_done), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("start_an", 32'(an), 32'hE);
    chk("start_seg", 32'(seg), 32'h40);

    count_on("on15", 15);
    fd_cnt = 0;
    for (int c = 0; c < 128; c++) begin
      tick(1);
      if (frame_done) fd_cnt++;
    end
    chk("fd_per_128", 32'(fd_cnt), 32'd2);

    wait_phase(4, 1);
    do_load(16'h12AF, 4'b0100, 4'b0000);
    tick(150);

    wait_phase(RD - 1, ND - 1);
    lz_blank = 1'b1;
    do_load(16'h0005, 4'b0000, 4'b0000);
    tick(70);
    wait_phase(8, 2);
    do_load(16'h0000, 4'b0000, 4'b0000);
    tick(140);

    lz_blank = 1'b0;
    brightness = 2'd0;
    do_load(16'h8888, 4'b0000, 4'b0000);
    tick(70);
    count_on("on4", 4);
    brightness = 2'd3;
    do_load(16'h8888, 4'b0000, 4'b0010);
    tick(140);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) begin
        bus_if.value_in = 16'($urandom);
        if ($urandom_range(0, 1) == 0) bus_if.value_in[15:8] = 8'h00;
        bus_if.dp_in    = 4'($urandom);
        bus_if.blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        bus_if.load     = 1'b1;
      end else begin
        bus_if.load = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 199) == 0) lz_blank = ~lz_blank;
      tick(1);
    end
    bus_if.load = 1'b0;
    brightness = 2'd3;
    lz_blank = 1'b0;
    do_load(16'h4321, 4'b0000, 4'b0000);
    tick(140);

    wait_phase(6, 2);
    reset = 1'b1;
    tick(1);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    tick(1);
    chk("restart_an", 32'(an), 32'hE);
    chk("restart_seg", 32'(seg), 32'h40);
    tick(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
